// File: rtl/mfp_adc_max10_emu_pkg.sv
// Shared types for the MAX10 ADC emulator: command record, converter states and
// widths taken from the core header.
package mfp_adc_max10_emu_pkg;

`include "mfp_adc_max10_core.vh"

    localparam int ADC_DW = `MFP_ADC_DATA_W;
    localparam int CH_W   = `MFP_ADC_CH_W;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            sop;
        logic            eop;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Down-counter reload value; the conversion spends this+1 cycles in S_CONV.
    function automatic logic [7:0] conv_load(input int cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/mfp_adc_max10_core.vh
// Shared MAX10 ADC core definitions: data width, channel-field width and channel codes.
// Guarded so several compilation units may include it.
`ifndef MFP_ADC_MAX10_CORE_VH
`define MFP_ADC_MAX10_CORE_VH

`define MFP_ADC_DATA_W      12
`define MFP_ADC_CH_W        5

`define MFP_ADC_CH_ANAIN1   5'd1
`define MFP_ADC_CH_ADC1     5'd2
`define MFP_ADC_CH_ADC2     5'd3
`define MFP_ADC_CH_ADC3     5'd4
`define MFP_ADC_CH_ADC4     5'd5
`define MFP_ADC_CH_ADC5     5'd6
`define MFP_ADC_CH_ADC6     5'd7
`define MFP_ADC_CH_ADC7     5'd8
`define MFP_ADC_CH_ADC8     5'd9
`define MFP_ADC_CH_TSD      5'd17

`endif

// File: rtl/mfp_adc_max10_emu_fifo.sv
// Command buffer for the ADC emulator: power-of-two depth, occupancy-count based
// full/empty, head entry visible combinationally so the converter can pop and use it.
module mfp_adc_max10_emu_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage carries no reset: entries are only read once the count covers them.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk) begin
                if (w_push && (r_wr_ptr == AW'(gi))) begin
                    r_mem[gi] <= i_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mfp_adc_max10_emu.sv
// Behavioural emulator of the MAX10 modular ADC command/response interface.
// Optional command-stream checker enabled by defining MFP_ADC_MAX10_EMU_PROTOCHECK_EN.
module mfp_adc_max10_emu
    import mfp_adc_max10_emu_pkg::*;
#(
    parameter int CONV_CYCLES = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              ADC_C_Valid,
    input  logic [CH_W-1:0]   ADC_C_Channel,
    input  logic              ADC_C_SOP,
    input  logic              ADC_C_EOP,
    output logic              ADC_C_Ready,
    output logic              ADC_R_Valid,
    output logic [CH_W-1:0]   ADC_R_Channel,
    output logic [ADC_DW-1:0] ADC_R_Data,
    output logic              ADC_R_SOP,
    output logic              ADC_R_EOP,
    output logic [CH_W-1:0]   sample_channel,
    input  logic [ADC_DW-1:0] sample_data,
    output logic              proto_err
);

    localparam logic [7:0] CNT_LOAD = conv_load(CONV_CYCLES);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [CH_W-1:0]   r_sample_ch;
    logic              r_act_sop;
    logic              r_act_eop;
    logic              r_rsp_valid;
    logic [CH_W-1:0]   r_rsp_ch;
    logic [ADC_DW-1:0] r_rsp_data;
    logic              r_rsp_sop;
    logic              r_rsp_eop;

    cmd_t              w_push_cmd;
    cmd_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_pop;

    assign w_push_cmd = '{ch: ADC_C_Channel, sop: ADC_C_SOP, eop: ADC_C_EOP};
    assign ADC_C_Ready = RESETn & ~w_full;
    assign w_accept    = ADC_C_Valid & ADC_C_Ready;
    assign w_pop       = ((r_state == S_IDLE) || (r_state == S_RESP)) & ~w_empty;

    mfp_adc_max10_emu_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESETn),
        .i_push  (w_accept),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Response fields only change when a result is published, so they hold between responses.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sample_ch <= '0;
            r_act_sop   <= 1'b0;
            r_act_eop   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_ch    <= '0;
            r_rsp_data  <= '0;
            r_rsp_sop   <= 1'b0;
            r_rsp_eop   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (!w_empty) begin
                        r_cnt       <= CNT_LOAD;
                        r_sample_ch <= w_head.ch;
                        r_act_sop   <= w_head.sop;
                        r_act_eop   <= w_head.eop;
                        r_state     <= S_CONV;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                end
                S_CONV: begin
                    if (r_cnt == 8'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_ch    <= r_sample_ch;
                        r_rsp_data  <= sample_data;
                        r_rsp_sop   <= r_act_sop;
                        r_rsp_eop   <= r_act_eop;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt       <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ADC_R_Valid    = r_rsp_valid;
    assign ADC_R_Channel  = r_rsp_ch;
    assign ADC_R_Data     = r_rsp_data;
    assign ADC_R_SOP      = r_rsp_sop;
    assign ADC_R_EOP      = r_rsp_eop;
    assign sample_channel = r_sample_ch;

`ifdef MFP_ADC_MAX10_EMU_PROTOCHECK_EN
    logic r_pkt_open;
    logic r_proto_err;
    logic r_wait_acc;

    // r_wait_acc remembers a command offered but not taken, to catch it being withdrawn.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_pkt_open  <= 1'b0;
            r_proto_err <= 1'b0;
            r_wait_acc  <= 1'b0;
        end else begin
            r_wait_acc <= ADC_C_Valid & ~ADC_C_Ready;
            if (w_accept) begin
                if (ADC_C_SOP) begin
                    r_pkt_open <= ~ADC_C_EOP;
                end else if (ADC_C_EOP) begin
                    r_pkt_open <= 1'b0;
                end
            end
            if ((w_accept && ADC_C_SOP && r_pkt_open) ||
                (w_accept && !ADC_C_SOP && !r_pkt_open) ||
                (r_wait_acc && !ADC_C_Valid)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mfp_adc_max10_emu.sv
// Scoreboard bench for mfp_adc_max10_emu: the driver queues expected responses on
// acceptance, a negedge monitor pops and compares each ADC_R_Valid beat.
module tb_mfp_adc_max10_emu;
    import mfp_adc_max10_emu_pkg::*;

    localparam int C = 8;
    localparam int D = 4;
`ifdef MFP_ADC_MAX10_EMU_PROTOCHECK_EN
    localparam int EXP_PROTO = 1;
`else
    localparam int EXP_PROTO = 0;
`endif

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        ADC_C_Valid;
    logic [4:0]  ADC_C_Channel;
    logic        ADC_C_SOP;
    logic        ADC_C_EOP;
    logic        ADC_C_Ready;
    logic        ADC_R_Valid;
    logic [4:0]  ADC_R_Channel;
    logic [11:0] ADC_R_Data;
    logic        ADC_R_SOP;
    logic        ADC_R_EOP;
    logic [4:0]  sample_channel;
    logic [11:0] sample_data;
    logic        proto_err;

    logic [11:0] chan_val [32];
    assign sample_data = chan_val[sample_channel];

    mfp_adc_max10_emu #(.CONV_CYCLES(C), .FIFO_DEPTH(D)) dut (
        .CLK            (CLK),
        .RESETn         (RESETn),
        .ADC_C_Valid    (ADC_C_Valid),
        .ADC_C_Channel  (ADC_C_Channel),
        .ADC_C_SOP      (ADC_C_SOP),
        .ADC_C_EOP      (ADC_C_EOP),
        .ADC_C_Ready    (ADC_C_Ready),
        .ADC_R_Valid    (ADC_R_Valid),
        .ADC_R_Channel  (ADC_R_Channel),
        .ADC_R_Data     (ADC_R_Data),
        .ADC_R_SOP      (ADC_R_SOP),
        .ADC_R_EOP      (ADC_R_EOP),
        .sample_channel (sample_channel),
        .sample_data    (sample_data),
        .proto_err      (proto_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  ch;
        logic [11:0] data;
        logic        sop;
        logic        eop;
        int          at_edge;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   resp_cnt = 0;
    int   last_resp = -1000;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per response, checks hold behaviour otherwise.
    exp_t        mon_e;
    logic [4:0]  last_ch;
    logic [11:0] last_data;
    logic        last_sop;
    logic        last_eop;
    always @(negedge CLK) begin
        if (!RESETn) begin
            last_ch = '0; last_data = '0; last_sop = 1'b0; last_eop = 1'b0;
        end else if (ADC_R_Valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_ch", int'(ADC_R_Channel), int'(mon_e.ch));
                chk("rsp_data", int'(ADC_R_Data), int'(mon_e.data));
                chk("rsp_sop", int'(ADC_R_SOP), int'(mon_e.sop));
                chk("rsp_eop", int'(ADC_R_EOP), int'(mon_e.eop));
                chk("rsp_edge", cyc, mon_e.at_edge);
            end
            $display("resp #%0d: ch=%0d data=0x%0h sop=%0b eop=%0b edge=%0d",
                     resp_cnt, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP, cyc);
            last_ch = ADC_R_Channel; last_data = ADC_R_Data;
            last_sop = ADC_R_SOP; last_eop = ADC_R_EOP;
        end else begin
            chk("rsp_hold", int'({ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP}),
                int'({last_ch, last_data, last_sop, last_eop}));
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [4:0] ch, input logic s, input logic e);
        int   w;
        int   acc;
        int   rsp;
        exp_t x;
        w = 0;
        ADC_C_Valid = 1'b1; ADC_C_Channel = ch; ADC_C_SOP = s; ADC_C_EOP = e;
        while (!ADC_C_Ready && w < 200) begin
            @(negedge CLK);
            w++;
        end
        if (!ADC_C_Ready) begin
            chk("send_timeout", 0, 1);
            ADC_C_Valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        rsp = acc + C + 1;
        if (last_resp + C + 1 > rsp) rsp = last_resp + C + 1;
        last_resp = rsp;
        x.ch = ch; x.data = chan_val[ch]; x.sop = s; x.eop = e; x.at_edge = rsp;
        sb.push_back(x);
        $display("cmd: ch=%0d sop=%0b eop=%0b accepted at edge %0d, expect resp edge %0d",
                 ch, s, e, acc, rsp);
        @(negedge CLK);
        ADC_C_Valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(ADC_C_Ready), 0);
        chk({tag, "_rvalid"}, int'(ADC_R_Valid), 0);
        chk({tag, "_rch"}, int'(ADC_R_Channel), 0);
        chk({tag, "_rdata"}, int'(ADC_R_Data), 0);
        chk({tag, "_rsopeop"}, int'({ADC_R_SOP, ADC_R_EOP}), 0);
        chk({tag, "_sample_ch"}, int'(sample_channel), 0);
        chk({tag, "_proto"}, int'(proto_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        for (int i = 0; i < 32; i++) chan_val[i] = 12'(12'h100 + i * 12'h0A5);
        chan_val[1] = 12'hABC;
        RESETn = 1'b0;
        ADC_C_Valid = 1'b0; ADC_C_Channel = '0; ADC_C_SOP = 1'b0; ADC_C_EOP = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_outputs("por");
        #2 RESETn = 1'b1;
        @(negedge CLK);
        chk("ready_after_rst", int'(ADC_C_Ready), 1);

        // Single command, latency CONV_CYCLES+1 edges.
        send(5'd1, 1'b1, 1'b1);
        wait_drain(60);
        chk("proto_single", int'(proto_err), 0);

        // Burst of three, back-to-back conversions.
        send(5'd0, 1'b1, 1'b0);
        send(5'd1, 1'b0, 1'b0);
        send(5'd2, 1'b0, 1'b1);
        wait_drain(100);
        chk("proto_burst", int'(proto_err), 0);

        // Six commands into a four-deep buffer.
        cnt0 = resp_cnt;
        send(5'd3, 1'b1, 1'b0);
        send(5'd4, 1'b0, 1'b0);
        send(5'd5, 1'b0, 1'b0);
        send(5'd6, 1'b0, 1'b0);
        chk("ready_three_buffered", int'(ADC_C_Ready), 1);
        send(5'd7, 1'b0, 1'b0);
        chk("ready_full", int'(ADC_C_Ready), 0);
        send(5'd8, 1'b0, 1'b1);
        wait_drain(200);
        chk("full_resp_count", resp_cnt - cnt0, 6);
        chk("proto_full", int'(proto_err), 0);

        // Reset mid-conversion with two queued.
        send(5'd9, 1'b1, 1'b0);
        send(5'd10, 1'b0, 1'b0);
        send(5'd11, 1'b0, 1'b1);
        repeat (2) @(negedge CLK);
        chk("conv_sample_ch", int'(sample_channel), 9);
        #2 RESETn = 1'b0;
        #1 chk_reset_outputs("midrst");
        sb.delete();
        last_resp = -1000;
        repeat (2) @(negedge CLK);
        chk("ready_in_rst", int'(ADC_C_Ready), 0);
        #2 RESETn = 1'b1;
        @(negedge CLK);
        cnt0 = resp_cnt;
        repeat (40) @(negedge CLK);
        chk("no_resp_after_rst", resp_cnt, cnt0);
        send(5'd6, 1'b1, 1'b1);
        wait_drain(60);
        chk("fresh_resp_count", resp_cnt - cnt0, 1);

        // SOP, SOP without EOP in between.
        send(5'd12, 1'b1, 1'b0);
        send(5'd13, 1'b1, 1'b0);
        repeat (2) @(negedge CLK);
        chk("proto_double_sop", int'(proto_err), EXP_PROTO);
        send(5'd14, 1'b0, 1'b1);
        wait_drain(100);
        repeat (5) @(negedge CLK);
        chk("proto_sticky", int'(proto_err), EXP_PROTO);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
